// File: rtl/logic_cell_pkg.sv
// Shared types and the per-lane evaluation function for logic_cell_pipe.
package logic_cell_pkg;

  typedef enum logic [1:0] {
    MODE_AOR_AND = 2'b00,
    MODE_AAND_OR = 2'b01,
    MODE_XOR     = 2'b10,
    MODE_NOT     = 2'b11
  } lc_mode_e;

  localparam int unsigned LC_STATS_W = 16;

  // Evaluates one bit lane. All modes are bitwise, so lanes are independent
  // and the caller applies this across any operand width. Returns {x, y}.
  function automatic logic [1:0] lc_eval(input lc_mode_e mode, input logic a,
                                         input logic b, input logic c, input logic d);
    logic [1:0] r;
    r = 2'b00;
    case (mode)
      MODE_AOR_AND: r = {a | (b & c), b & d};
      MODE_AAND_OR: r = {a & (b | c), b | d};
      MODE_XOR:     r = {a ^ (b & c), b ^ d};
      MODE_NOT:     r = {~(a | (b & c)), ~(b & d)};
      default:      r = 2'b00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lc_result_fifo.sv
// Synchronous result FIFO with a registered head entry. The head register
// holds the last popped value once the queue drains.
module lc_result_fifo #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] head_q, head_d;
  logic              full_q, full_d, empty_q, empty_d;
  logic              push_ok, pop_ok;

  // Next-state for pointers, occupancy, flags and the head register.
  always_comb begin
    push_ok  = push & ~full_q;
    pop_ok   = pop & ~empty_q;
    rd_ptr_d = rd_ptr_q + PTR_W'(pop_ok);
    wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
    count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    full_d   = (count_d == CNT_W'(DEPTH));
    empty_d  = (count_d == '0);
    head_d   = head_q;
    // The slot being written becomes the head only when the queue is empty
    // or its single entry is leaving in the same cycle.
    if (push_ok && (wr_ptr_q == rd_ptr_d)) begin
      head_d = wdata;
    end else if (pop_ok && !empty_d) begin
      head_d = mem_q[rd_ptr_d];
    end
  end

  // State registers, asynchronously cleared.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  assign rdata = head_q;
  assign full  = full_q;
  assign empty = empty_q;
  assign count = count_q;

endmodule

// File: rtl/logic_cell_pipe.sv
// Registered, flow-controlled two-output logic cell.
// Optional macro LOGIC_CELL_STATS_EN adds a saturating pop_count output.
module logic_cell_pipe
  import logic_cell_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y,
  output logic [CNT_W-1:0] occupancy
`ifdef LOGIC_CELL_STATS_EN
  ,
  output logic [LC_STATS_W-1:0] pop_count
`endif
);

  logic               push, pop, full, empty;
  logic [WIDTH-1:0]   x_new, y_new;
  logic [2*WIDTH-1:0] head;

  assign in_ready  = ~full;
  assign out_valid = ~empty;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Lane-by-lane evaluation of the incoming beat.
  always_comb begin
    x_new = '0;
    y_new = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      {x_new[i], y_new[i]} = lc_eval(lc_mode_e'(mode), a[i], b[i], c[i], d[i]);
    end
  end

  lc_result_fifo #(
    .DATA_W (2 * WIDTH),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata ({x_new, y_new}),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (occupancy)
  );

  assign x = head[2*WIDTH-1:WIDTH];
  assign y = head[WIDTH-1:0];

`ifdef LOGIC_CELL_STATS_EN
  logic [LC_STATS_W-1:0] pop_count_q, pop_count_d;

  // Saturating count of popped results.
  always_comb begin
    pop_count_d = pop_count_q;
    if (pop && (pop_count_q != '1)) begin
      pop_count_d = pop_count_q + LC_STATS_W'(1);
    end
  end

  // Pop counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pop_count_q <= '0;
    end else begin
      pop_count_q <= pop_count_d;
    end
  end

  assign pop_count = pop_count_q;
`endif

endmodule

// File: tb/tb_logic_cell_pipe.sv
// Directed testbench for logic_cell_pipe (WIDTH=8, DEPTH=4).
module tb_logic_cell_pipe;

  logic       clk, reset;
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [1:0] mode;
  logic [7:0] a, b, c, d, x, y;
  logic [2:0] occupancy;
`ifdef LOGIC_CELL_STATS_EN
  logic [15:0] pop_count;
`endif

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_a;

  logic_cell_pipe #(.WIDTH(8), .DEPTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .a         (a),
    .b         (b),
    .c         (c),
    .d         (d),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .x         (x),
    .y         (y),
    .occupancy (occupancy)
`ifdef LOGIC_CELL_STATS_EN
    ,
    .pop_count (pop_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    mode = 2'b00; a = '0; b = '0; c = '0; d = '0;
    #12 reset = 1'b0;
    step();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_occupancy", 32'(occupancy), 32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_x",         32'(x),         32'd0);
    check("rst_y",         32'(y),         32'd0);

    // Per-mode results, one beat each with out_ready high.
    out_ready = 1'b1; a = 8'h0F; b = 8'hF0; c = 8'h3C; d = 8'hAA;
    mode = 2'b00; in_valid = 1'b1; step(); in_valid = 1'b0;
    check("m00_valid", 32'(out_valid), 32'd1);
    check("m00_x", 32'(x), 32'h3F);
    check("m00_y", 32'(y), 32'hA0);
    step();
    check("m00_drained", 32'(out_valid), 32'd0);
    check("m00_hold_x", 32'(x), 32'h3F);
    mode = 2'b01; in_valid = 1'b1; step(); in_valid = 1'b0;
    check("m01_valid", 32'(out_valid), 32'd1);
    check("m01_x", 32'(x), 32'h0C);
    check("m01_y", 32'(y), 32'hFA);
    step();
    mode = 2'b10; in_valid = 1'b1; step(); in_valid = 1'b0;
    check("m10_valid", 32'(out_valid), 32'd1);
    check("m10_x", 32'(x), 32'h3F);
    check("m10_y", 32'(y), 32'h5A);
    step();
    mode = 2'b11; in_valid = 1'b1; step(); in_valid = 1'b0;
    check("m11_valid", 32'(out_valid), 32'd1);
    check("m11_x", 32'(x), 32'hC0);
    check("m11_y", 32'(y), 32'h5F);
    step();
    check("m11_hold_y", 32'(y), 32'h5F);

    // Fill with the consumer stalled; mode 00 with b=c=d=0 gives x=a, y=0.
    out_ready = 1'b0; mode = 2'b00; b = '0; c = '0; d = '0;
    in_valid = 1'b1;
    a = 8'h10; step();
    a = 8'h11; step();
    a = 8'h12; step();
    a = 8'h13; step();
    check("fill_occ4", 32'(occupancy), 32'd4);
    check("fill_in_ready0", 32'(in_ready), 32'd0);
    a = 8'h14; step();
    check("fill_stalled_occ", 32'(occupancy), 32'd4);
    check("fill_head_x", 32'(x), 32'h10);
    // Full with in_valid and out_ready together: only the pop happens.
    out_ready = 1'b1; step();
    check("full_pop_occ3", 32'(occupancy), 32'd3);
    check("full_pop_in_ready", 32'(in_ready), 32'd1);
    check("drain_x11", 32'(x), 32'h11);
    step(); in_valid = 1'b0;
    check("push_pop_occ3", 32'(occupancy), 32'd3);
    check("drain_x12", 32'(x), 32'h12);
    step();
    check("drain_x13", 32'(x), 32'h13);
    check("drain_occ2", 32'(occupancy), 32'd2);
    step();
    check("drain_x14", 32'(x), 32'h14);
    step();
    check("drain_empty", 32'(out_valid), 32'd0);
    check("drain_hold_x", 32'(x), 32'h14);

    // Steady streaming: occupancy stays 1, x trails a by one cycle.
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      a = 8'(i);
      step();
      check("stream_occ", 32'(occupancy), 32'd1);
      check("stream_valid", 32'(out_valid), 32'd1);
      check("stream_x", 32'(x), 32'(i));
    end
    in_valid = 1'b0; step();
    check("stream_end_empty", 32'(occupancy), 32'd0);

    // Pointer wrap: bursts of three pushes then three pops.
    exp_a = 8'h40;
    for (int r = 0; r < 4; r++) begin
      out_ready = 1'b0; in_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
        a = 8'h40 + 8'(r * 3 + k);
        step();
        check("wrap_push_occ", 32'(occupancy), 32'(k + 1));
      end
      in_valid = 1'b0; out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
        check("wrap_head_x", 32'(x), 32'(exp_a));
        step();
        exp_a = exp_a + 8'd1;
      end
      check("wrap_empty_occ", 32'(occupancy), 32'd0);
    end

`ifdef LOGIC_CELL_STATS_EN
    check("stats_pop_count", 32'(pop_count), 32'd41);
`endif

    // Asynchronous reset with three results queued.
    out_ready = 1'b0; in_valid = 1'b1; b = 8'hFF; d = 8'h55;
    a = 8'h77; step();
    a = 8'h78; step();
    a = 8'h79; step();
    in_valid = 1'b0;
    check("pre_rst_occ3", 32'(occupancy), 32'd3);
    check("pre_rst_y", 32'(y), 32'h55);
    #2 reset = 1'b1;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_occ", 32'(occupancy), 32'd0);
    check("arst_x", 32'(x), 32'd0);
    check("arst_y", 32'(y), 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'd1);
`ifdef LOGIC_CELL_STATS_EN
    check("arst_pop_count", 32'(pop_count), 32'd0);
`endif
    #3 reset = 1'b0;
    step();
    b = '0; d = '0; a = 8'h99; in_valid = 1'b1; step(); in_valid = 1'b0;
    check("post_rst_valid", 32'(out_valid), 32'd1);
    check("post_rst_x", 32'(x), 32'h99);
    check("post_rst_occ", 32'(occupancy), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
